param_data_buffer: RTL and testbench

Parametrised successor to the USB endpoint `data_buffer`. It is a circular byte FIFO with depth `DEPTH` between the USB RX/TX byte paths and the AHB-Lite slave word path. Word access width (`WORD_BYTES`) is configurable. It adds sticky overflow/underflow error flags, full/empty status and optional packet commit/abort rollback for the USB RX side.

---
 rtl/data_buffer_pkg.sv | 37 +++
 rtl/buffer_regfile.sv | 35 +++
 rtl/param_data_buffer.sv | 155 +++++++++++++++
 tb/tb_param_data_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_buffer_pkg.sv
// Shared constants and helpers for the parametrised USB endpoint data buffer.
// Optional build macro: DATA_BUFFER_ROLLBACK_EN (RX packet commit/abort rollback).
package data_buffer_pkg;

    localparam int BYTE_W         = 8;
    localparam int MAX_WORD_BYTES = 8;

    // data_size encodings (byte count minus one)
    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd3;
    localparam logic [2:0] SIZE_DWORD = 3'd7;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int sz_width(input int word_bytes);
        return (word_bytes > 1) ? $clog2(word_bytes) : 1;
    endfunction

    // Little-endian lane access on a maximum-width word
    function automatic logic [BYTE_W-1:0] get_lane(input logic [8*MAX_WORD_BYTES-1:0] word,
                                                   input int k);
        return word[BYTE_W*k +: BYTE_W];
    endfunction

    function automatic logic [8*MAX_WORD_BYTES-1:0] set_lane(input logic [8*MAX_WORD_BYTES-1:0] word,
                                                            input int k,
                                                            input logic [BYTE_W-1:0] b);
        logic [8*MAX_WORD_BYTES-1:0] w;
        w = word;
        w[BYTE_W*k +: BYTE_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/buffer_regfile.sv
// Byte-wide storage array with WORD_BYTES write lanes and WORD_BYTES read lanes.
// Lane k addresses base+k modulo DEPTH, so words straddle the wrap point naturally.
module buffer_regfile
    import data_buffer_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WORD_BYTES = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic [AW-1:0]                wr_base,
    input  logic [WORD_BYTES-1:0]        lane_we,
    input  logic [BYTE_W*WORD_BYTES-1:0] lane_wdata,
    input  logic [AW-1:0]                rd_base,
    output logic [BYTE_W*WORD_BYTES-1:0] lane_rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (lane_we[k]) begin
                mem[wr_base + AW'(k)] <= lane_wdata[BYTE_W*k +: BYTE_W];
            end
        end
    end

    always_comb begin
        lane_rdata = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            lane_rdata[BYTE_W*k +: BYTE_W] = mem[rd_base + AW'(k)];
        end
    end

endmodule

// File: rtl/param_data_buffer.sv
// Circular byte FIFO between USB RX/TX byte paths and an AHB word path.
// Optional build macro: DATA_BUFFER_ROLLBACK_EN enables pending RX bytes with commit/abort.
module param_data_buffer
    import data_buffer_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WORD_BYTES = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int OW        = occ_width(DEPTH),
    localparam int SZ_W      = sz_width(WORD_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    store_rx_packet_data,
    input  logic [7:0]              rx_packet_data,
    input  logic                    get_rx_data,
    input  logic [SZ_W-1:0]         data_size,
    output logic [8*WORD_BYTES-1:0] rx_data,
    input  logic                    store_tx_data,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic                    get_tx_packet_data,
    output logic [7:0]              tx_packet_data,
    input  logic                    commit,
    input  logic                    abort,
    output logic [OW-1:0]           buffer_occupancy,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic                    underflow
);

    // Strobes carry no ready: every cycle a strobe is sampled high is one attempt,
    // which either completes entirely on that edge or is dropped and flagged sticky.

    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [OW-1:0] occ, occ_nx, pend, pend_nx, wr_cnt, rd_cnt;
    logic [31:0]   n_req, free_cnt;
    logic          size_ok;
    logic          word_push_ok, byte_push_ok, word_pop_ok, byte_pop_ok;
    logic          wr_reject, rd_reject;

    logic [WORD_BYTES-1:0]        lane_we;
    logic [8*WORD_BYTES-1:0]      lane_wdata, lane_rdata, rx_word;

    buffer_regfile #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_regfile (
        .clk        (clk),
        .wr_base    (wr_ptr),
        .lane_we    (lane_we),
        .lane_wdata (lane_wdata),
        .rd_base    (rd_ptr),
        .lane_rdata (lane_rdata)
    );

    // Admission: word transfers win arbitration, the losing byte strobe is a reject
    always_comb begin
        n_req        = 32'(data_size) + 32'd1;
        size_ok      = (n_req <= 32'(WORD_BYTES));
        free_cnt     = 32'(DEPTH) - 32'(occ) - 32'(pend);
        word_push_ok = store_tx_data && size_ok && (n_req <= free_cnt);
        byte_push_ok = store_rx_packet_data && !store_tx_data && (free_cnt != 32'd0);
        wr_reject    = (store_tx_data && !word_push_ok) ||
                       (store_rx_packet_data && !byte_push_ok);
        word_pop_ok  = get_rx_data && size_ok && (n_req <= 32'(occ));
        byte_pop_ok  = get_tx_packet_data && !get_rx_data && (occ != '0);
        rd_reject    = (get_rx_data && !word_pop_ok) ||
                       (get_tx_packet_data && !byte_pop_ok);
        wr_cnt       = word_push_ok ? OW'(n_req) : (byte_push_ok ? OW'(1) : '0);
        rd_cnt       = word_pop_ok  ? OW'(n_req) : (byte_pop_ok  ? OW'(1) : '0);
    end

    always_comb begin
        lane_we    = '0;
        lane_wdata = '0;
        rx_word    = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            lane_wdata[8*k +: 8] = get_lane((8*MAX_WORD_BYTES)'(tx_data), k);
            if (word_push_ok && (32'(k) < n_req)) begin
                lane_we[k] = 1'b1;
            end
            // Unused upper lanes of a short word pop read back as zero
            rx_word[8*k +: 8] = (32'(k) < n_req) ? lane_rdata[8*k +: 8] : 8'h00;
        end
        if (byte_push_ok) begin
            lane_we[0]       = 1'b1;
            lane_wdata[7:0]  = rx_packet_data;
        end
    end

    always_comb begin
        rd_ptr_nx = rd_ptr + AW'(rd_cnt);
        wr_ptr_nx = wr_ptr + AW'(wr_cnt);
`ifdef DATA_BUFFER_ROLLBACK_EN
        // Byte pushes stay pending; a word push folds pending bytes in ahead of itself
        pend_nx = word_push_ok ? '0 : (pend + (byte_push_ok ? OW'(1) : '0));
        occ_nx  = occ - rd_cnt + (word_push_ok ? (pend + wr_cnt) : '0);
        if (abort) begin
            wr_ptr_nx = wr_ptr_nx - AW'(pend_nx);
            pend_nx   = '0;
        end else if (commit) begin
            occ_nx  = occ_nx + pend_nx;
            pend_nx = '0;
        end
`else
        pend_nx = '0;
        occ_nx  = occ - rd_cnt + wr_cnt;
`endif
    end

`ifndef DATA_BUFFER_ROLLBACK_EN
    logic unused_rollback_ctrl;
    assign unused_rollback_ctrl = commit ^ abort;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            pend           <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            rx_data        <= '0;
            tx_packet_data <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            pend      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            occ       <= occ_nx;
            pend      <= pend_nx;
            overflow  <= overflow | wr_reject;
            underflow <= underflow | rd_reject;
            if (word_pop_ok) begin
                rx_data <= rx_word;
            end
            if (byte_pop_ok) begin
                tx_packet_data <= lane_rdata[7:0];
            end
        end
    end

    assign buffer_occupancy = occ;
    assign full             = ((32'(occ) + 32'(pend)) == 32'(DEPTH));
    assign empty            = (occ == '0);

endmodule

// File: tb/tb_param_data_buffer.sv
// Directed self-checking bench for param_data_buffer (DEPTH=64, WORD_BYTES=4).
// Builds with or without DATA_BUFFER_ROLLBACK_EN; the commit/abort scenario follows the macro.
module tb_param_data_buffer;
    import data_buffer_pkg::*;

    logic        tb_clk = 1'b0;
    logic        rst = 1'b1, clear = 1'b0;
    logic        store_rx_packet_data = 1'b0, get_rx_data = 1'b0;
    logic        store_tx_data = 1'b0, get_tx_packet_data = 1'b0;
    logic        commit = 1'b0, abort = 1'b0;
    logic [7:0]  rx_packet_data = '0;
    logic [1:0]  data_size = '0;
    logic [31:0] tx_data = '0;
    logic [31:0] rx_data;
    logic [7:0]  tx_packet_data;
    logic [6:0]  buffer_occupancy;
    logic        full, empty, overflow, underflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    param_data_buffer #(.DEPTH(64), .WORD_BYTES(4)) dut (
        .clk                  (tb_clk),
        .rst                  (rst),
        .clear                (clear),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_rx_data          (get_rx_data),
        .data_size            (data_size),
        .rx_data              (rx_data),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .commit               (commit),
        .abort                (abort),
        .buffer_occupancy     (buffer_occupancy),
        .full                 (full),
        .empty                (empty),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    always #5 tb_clk = ~tb_clk;

    // Driver tasks: inputs change 1 time unit after the active edge
    task automatic cycle();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        store_rx_packet_data = 1'b1;
        rx_packet_data = b;
        cycle();
        store_rx_packet_data = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input logic [1:0] ds);
        store_tx_data = 1'b1;
        tx_data = w;
        data_size = ds;
        cycle();
        store_tx_data = 1'b0;
    endtask

    task automatic pop_word(input logic [1:0] ds);
        get_rx_data = 1'b1;
        data_size = ds;
        cycle();
        get_rx_data = 1'b0;
    endtask

    task automatic pop_byte();
        get_tx_packet_data = 1'b1;
        cycle();
        get_tx_packet_data = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++; if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", buffer_occupancy); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_status: empty=%b full=%b expected 1 0", empty, full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: ovf=%b unf=%b expected 0 0", overflow, underflow); end
        checks++; if (rx_data !== 32'h0 || tx_packet_data !== 8'h0) begin errors++; $display("FAIL reset_data: rx=%h tx=%h expected 0 0", rx_data, tx_packet_data); end
    endtask

    task automatic test_rx_word_pop();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        checks++; if (buffer_occupancy !== 7'd4) begin errors++; $display("FAIL rxw_occ4: got %0d expected 4", buffer_occupancy); end
        pop_word(SIZE_WORD[1:0]);
        checks++; if (rx_data !== 32'h44332211) begin errors++; $display("FAIL rxw_data: got %h expected 44332211", rx_data); end
        checks++; if (buffer_occupancy !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL rxw_occ0: occ=%0d empty=%b expected 0 1", buffer_occupancy, empty); end
    endtask

    task automatic test_tx_byte_pop();
        push_word(32'h0000BBAA, SIZE_HALF[1:0]);
        checks++; if (buffer_occupancy !== 7'd2) begin errors++; $display("FAIL txb_occ2: got %0d expected 2", buffer_occupancy); end
        pop_byte();
        checks++; if (tx_packet_data !== 8'hAA) begin errors++; $display("FAIL txb_first: got %h expected aa", tx_packet_data); end
        pop_byte();
        checks++; if (tx_packet_data !== 8'hBB || buffer_occupancy !== 7'd0) begin errors++; $display("FAIL txb_second: got %h occ %0d expected bb 0", tx_packet_data, buffer_occupancy); end
        pop_byte();
        checks++; if (underflow !== 1'b1 || tx_packet_data !== 8'hBB) begin errors++; $display("FAIL txb_empty_pop: unf=%b tx=%h expected 1 bb", underflow, tx_packet_data); end
        do_clear();
        checks++; if (underflow !== 1'b0 || tx_packet_data !== 8'hBB || rx_data !== 32'h44332211) begin errors++; $display("FAIL txb_clear: unf=%b tx=%h rx=%h expected 0 bb 44332211", underflow, tx_packet_data, rx_data); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        checks++; if (full !== 1'b1 || buffer_occupancy !== 7'd64) begin errors++; $display("FAIL full_64: full=%b occ=%0d expected 1 64", full, buffer_occupancy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b expected 0", overflow); end
        push_byte(8'hEE);
        checks++; if (overflow !== 1'b1 || buffer_occupancy !== 7'd64) begin errors++; $display("FAIL full_65th: ovf=%b occ=%0d expected 1 64", overflow, buffer_occupancy); end
        do_clear();
        checks++; if (buffer_occupancy !== 7'd0 || overflow !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL full_clear: occ=%0d ovf=%b empty=%b full=%b expected 0 0 1 0", buffer_occupancy, overflow, empty, full); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 62; i++) push_byte(8'(i));
        for (int i = 0; i < 15; i++) pop_word(SIZE_WORD[1:0]);
        checks++; if (rx_data !== 32'h3B3A3938) begin errors++; $display("FAIL wrap_fill_word: got %h expected 3b3a3938", rx_data); end
        pop_byte(); pop_byte();
        checks++; if (tx_packet_data !== 8'h3D || buffer_occupancy !== 7'd0) begin errors++; $display("FAIL wrap_drain: tx=%h occ=%0d expected 3d 0", tx_packet_data, buffer_occupancy); end
        push_word(32'hDDCCBBAA, SIZE_WORD[1:0]);
        checks++; if (buffer_occupancy !== 7'd4) begin errors++; $display("FAIL wrap_occ4: got %0d expected 4", buffer_occupancy); end
        pop_word(SIZE_WORD[1:0]);
        checks++; if (rx_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL wrap_word: got %h expected ddccbbaa", rx_data); end
        push_byte(8'h5A); push_byte(8'h6B);
        pop_word(SIZE_WORD[1:0]);
        checks++; if (underflow !== 1'b1 || rx_data !== 32'hDDCCBBAA || buffer_occupancy !== 7'd2) begin errors++; $display("FAIL wrap_short_pop: unf=%b rx=%h occ=%0d expected 1 ddccbbaa 2", underflow, rx_data, buffer_occupancy); end
        pop_word(SIZE_HALF[1:0]);
        checks++; if (rx_data !== 32'h00006B5A || buffer_occupancy !== 7'd0) begin errors++; $display("FAIL wrap_zero_fill: rx=%h occ=%0d expected 00006b5a 0", rx_data, buffer_occupancy); end
        do_clear();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        store_rx_packet_data = 1'b1; rx_packet_data = 8'h77; get_tx_packet_data = 1'b1;
        cycle();
        store_rx_packet_data = 1'b0; get_tx_packet_data = 1'b0;
        checks++; if (buffer_occupancy !== 7'd5 || tx_packet_data !== 8'h01) begin errors++; $display("FAIL b2b_push_pop: occ=%0d tx=%h expected 5 01", buffer_occupancy, tx_packet_data); end
        store_tx_data = 1'b1; tx_data = 32'h000000C3; data_size = SIZE_BYTE[1:0];
        store_rx_packet_data = 1'b1; rx_packet_data = 8'h99;
        cycle();
        store_tx_data = 1'b0; store_rx_packet_data = 1'b0;
        checks++; if (buffer_occupancy !== 7'd6 || overflow !== 1'b1) begin errors++; $display("FAIL b2b_write_arb: occ=%0d ovf=%b expected 6 1", buffer_occupancy, overflow); end
        exp_q = {8'h02, 8'h03, 8'h04, 8'h05, 8'h77, 8'hC3};
        while (exp_q.size() > 0) begin
            logic [7:0] exp_b;
            exp_b = exp_q.pop_front();
            pop_byte();
            checks++; if (tx_packet_data !== exp_b) begin errors++; $display("FAIL b2b_drain: got %h expected %h", tx_packet_data, exp_b); end
        end
        push_byte(8'hE1); push_byte(8'hE2);
        get_rx_data = 1'b1; data_size = SIZE_HALF[1:0]; get_tx_packet_data = 1'b1;
        cycle();
        get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
        checks++; if (rx_data !== 32'h0000E2E1 || tx_packet_data !== 8'hC3 || underflow !== 1'b1 || buffer_occupancy !== 7'd0) begin errors++; $display("FAIL b2b_read_arb: rx=%h tx=%h unf=%b occ=%0d expected 0000e2e1 c3 1 0", rx_data, tx_packet_data, underflow, buffer_occupancy); end
        do_clear();
    endtask

`ifdef DATA_BUFFER_ROLLBACK_EN
    task automatic test_rollback();
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
        checks++; if (buffer_occupancy !== 7'd0 || full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rb_pending: occ=%0d full=%b empty=%b expected 0 0 1", buffer_occupancy, full, empty); end
        abort = 1'b1; cycle(); abort = 1'b0;
        push_byte(8'hB1);
        commit = 1'b1; cycle(); commit = 1'b0;
        checks++; if (buffer_occupancy !== 7'd1) begin errors++; $display("FAIL rb_commit1: got %0d expected 1", buffer_occupancy); end
        pop_byte();
        checks++; if (tx_packet_data !== 8'hB1) begin errors++; $display("FAIL rb_abort_slot: got %h expected b1", tx_packet_data); end
        push_byte(8'hC1); push_byte(8'hC2);
        commit = 1'b1; push_byte(8'hC3); commit = 1'b0;
        checks++; if (buffer_occupancy !== 7'd3) begin errors++; $display("FAIL rb_commit3: got %0d expected 3", buffer_occupancy); end
        do_clear();
    endtask
`else
    task automatic test_rollback();
        push_byte(8'hA1); push_byte(8'hA2);
        checks++; if (buffer_occupancy !== 7'd2) begin errors++; $display("FAIL nrb_immediate: got %0d expected 2", buffer_occupancy); end
        abort = 1'b1; cycle(); abort = 1'b0;
        commit = 1'b1; cycle(); commit = 1'b0;
        checks++; if (buffer_occupancy !== 7'd2) begin errors++; $display("FAIL nrb_ignored: got %0d expected 2", buffer_occupancy); end
        pop_byte();
        checks++; if (tx_packet_data !== 8'hA1) begin errors++; $display("FAIL nrb_data: got %h expected a1", tx_packet_data); end
        do_clear();
    endtask
`endif

    task automatic test_reset_mid();
        push_byte(8'h12);
        pop_byte();
        push_byte(8'h34);
        rst = 1'b1; store_rx_packet_data = 1'b1; rx_packet_data = 8'h56;
        cycle();
        rst = 1'b0; store_rx_packet_data = 1'b0;
        checks++; if (buffer_occupancy !== 7'd0 || empty !== 1'b1 || tx_packet_data !== 8'h00 || rx_data !== 32'h0) begin errors++; $display("FAIL reset_mid: occ=%0d empty=%b tx=%h rx=%h expected 0 1 00 0", buffer_occupancy, empty, tx_packet_data, rx_data); end
    endtask

    initial begin
        test_reset();
        test_rx_word_pop();
        test_tx_byte_pop();
        test_full_overflow();
        test_wrap();
        test_back_to_back();
        test_rollback();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
